// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: DMA FSM states, register addresses, rw levels.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma_if.sv
// CPU snoop inputs and DMA bus-master outputs of the sprite DMA engine.
// slave: the DMA engine itself; master: the CPU/bus side that feeds it.
interface oam_dma_if;

    logic        i_cpu_rw;
    logic [15:0] i_cpu_address;
    logic [7:0]  i_cpu_data;
    logic [7:0]  i_data;

    logic        o_rdy;
    logic        o_dma_active;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic [2:0]  o_debug_state;

    modport slave (
        input  i_cpu_rw, i_cpu_address, i_cpu_data, i_data,
        output o_rdy, o_dma_active, o_address, o_rw, o_data, o_debug_state
    );

    modport master (
        output i_cpu_rw, i_cpu_address, i_cpu_data, i_data,
        input  o_rdy, o_dma_active, o_address, o_rw, o_data, o_debug_state
    );

endinterface

// File: rtl/oam_dma_cpu_cycle_parity.sv
// Free-running CPU cycle parity: 0 in the first cycle after reset, then 1,0,1...
module cpu_cycle_parity (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_parity
);

    logic parity_q, parity_d;

    // Toggle every cycle.
    always_comb parity_d = ~parity_q;

    // Parity register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) parity_q <= 1'b0;
        else            parity_q <= parity_d;
    end

    assign o_parity = parity_q;

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write of P to $4014 halts the CPU and copies $PP00-$PPFF
// to the OAM data port, alternating READ/WRITE cycles aligned to even parity.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    oam_dma_if.slave   bus
);
    import nes_bus_pkg::*;

    logic       parity;
    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] latch_q, latch_d;

    logic        rdy_q, rdy_d;
    logic        active_q, active_d;
    logic [15:0] address_q, address_d;
    logic        rw_q, rw_d;
    logic [7:0]  data_q, data_d;

    cpu_cycle_parity u_parity (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_parity  (parity)
    );

    // Next-state logic; bus outputs are derived from the next state so the
    // registered values line up with the cycle the FSM is in that state.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        latch_d = latch_q;

        case (state_q)
            IDLE: begin
                if (bus.i_cpu_rw == RW_WRITE && bus.i_cpu_address == DMA_REG_ADDR) begin
                    state_d = HALT;
                    page_d  = bus.i_cpu_data;
                    index_d = 8'h00;
                end
            end
            // Reads must land on parity 0; an extra dummy cycle fixes odd starts.
            HALT:  state_d = parity ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ: begin
                latch_d = bus.i_data;
                state_d = WRITE;
            end
            WRITE: begin
                index_d = index_q + 8'd1;
                state_d = (index_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase

        rdy_d    = (state_d == IDLE);
        active_d = (state_d != IDLE);
        rw_d     = (state_d == WRITE) ? RW_WRITE : RW_READ;
        data_d   = latch_d;
        case (state_d)
            READ:    address_d = {page_d, index_d};
            WRITE:   address_d = OAM_DATA_ADDR;
            default: address_d = 16'h0000;
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            page_q    <= 8'h00;
            index_q   <= 8'h00;
            latch_q   <= 8'h00;
            rdy_q     <= 1'b1;
            active_q  <= 1'b0;
            address_q <= 16'h0000;
            rw_q      <= RW_READ;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            index_q   <= index_d;
            latch_q   <= latch_d;
            rdy_q     <= rdy_d;
            active_q  <= active_d;
            address_q <= address_d;
            rw_q      <= rw_d;
            data_q    <= data_d;
        end
    end

    assign bus.o_rdy         = rdy_q;
    assign bus.o_dma_active  = active_q;
    assign bus.o_address     = address_q;
    assign bus.o_rw          = rw_q;
    assign bus.o_data        = data_q;
    assign bus.o_debug_state = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: behavioural trace model plus directed and random transfers.
module tb_oam_dma;
    import nes_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oam_dma_if bus();

    oam_dma dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Memory contents: page $02 holds i^$5A, other pages are offset by page.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[7:0] ^ 8'h5A) + (a[15:8] - 8'h02);
    endfunction

    // Junk on the data bus when the DMA is not reading.
    assign bus.i_data = (bus.o_rw == 1'b1) ? mem_byte(bus.o_address) : 8'hEE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        dma_state_e  st;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    bit          m_par = 1'b0;
    bit          armed = 1'b0;
    bit          was_reset = 1'b0;
    int          low_run = 0;
    int          last_low = 0;
    int          rd_cnt = 0;
    logic [15:0] first_rd = 16'h0;
    logic [15:0] last_rd = 16'h0;
    bit          saw_zero = 1'b0;

    // Model: on a trigger seen in an idle cycle, expand the whole transfer into
    // a per-cycle trace; then compare the DUT against the head of the trace.
    always @(posedge clk) begin
        logic        s_rst;
        logic        s_rw;
        logic [15:0] s_a;
        logic [7:0]  s_d;
        logic [15:0] ra;
        s_rst = rst_n;
        s_rw  = bus.i_cpu_rw;
        s_a   = bus.i_cpu_address;
        s_d   = bus.i_cpu_data;
        if (!s_rst) begin
            q.delete();
            cur       = '{IDLE, 16'h0, 8'h0};
            m_par     = 1'b0;
            armed     = 1'b1;
            was_reset = 1'b1;
        end else if (armed) begin
            was_reset = 1'b0;
            m_par     = !m_par;
            if (cur.st == IDLE && s_rw == 1'b0 && s_a == 16'h4014) begin
                q.push_back('{HALT, 16'h0, 8'h0});
                if (!m_par) q.push_back('{ALIGN, 16'h0, 8'h0});
                for (int i = 0; i < 256; i++) begin
                    ra = {s_d, 8'(i)};
                    q.push_back('{READ, ra, 8'h0});
                    q.push_back('{WRITE, 16'h2004, mem_byte(ra)});
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = '{IDLE, 16'h0, 8'h0};
        end
        if (armed) begin
            #1;
            check("rdy", 32'(bus.o_rdy), 32'(cur.st == IDLE));
            check("dma_active", 32'(bus.o_dma_active), 32'(cur.st != IDLE));
            check("state", 32'(bus.o_debug_state), 32'(cur.st));
            check("rw", 32'(bus.o_rw), 32'(cur.st != WRITE));
            if (cur.st == READ || cur.st == WRITE)
                check("address", 32'(bus.o_address), 32'(cur.addr));
            if (cur.st == WRITE)
                check("wdata", 32'(bus.o_data), 32'(cur.data));
            if (was_reset) begin
                check("rst_address", 32'(bus.o_address), 32'h0);
                check("rst_data", 32'(bus.o_data), 32'h0);
            end
            if (bus.o_rdy == 1'b0) low_run++;
            else begin
                if (low_run > 0) last_low = low_run;
                low_run = 0;
            end
            if (bus.o_debug_state == 3'(READ)) begin
                rd_cnt++;
                if (rd_cnt == 1) first_rd = bus.o_address;
                last_rd = bus.o_address;
                if (bus.o_address == 16'h0000) saw_zero = 1'b1;
            end
        end
    end

    // One CPU bus cycle: drive at a falling edge, return at the next one.
    task automatic cyc(input logic rw, input logic [15:0] a, input logic [7:0] d);
        bus.i_cpu_rw      = rw;
        bus.i_cpu_address = a;
        bus.i_cpu_data    = d;
        @(negedge clk);
    endtask

    // Random CPU traffic; never a trigger while idle, sometimes one while busy.
    task automatic noise();
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
        rw = 1'($urandom);
        a  = 16'($urandom);
        d  = 8'($urandom);
        if (!bus.o_rdy && $urandom_range(7) == 0) begin
            rw = 1'b0;
            a  = 16'h4014;
        end
        if (bus.o_rdy && !rw && a == 16'h4014) rw = 1'b1;
        cyc(rw, a, d);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (!bus.o_rdy && n < maxc) begin
            noise();
            n++;
        end
        if (!bus.o_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: rdy still %0b after %0d cycles, required 1", bus.o_rdy, maxc);
        end
    endtask

    task automatic start(input logic [7:0] page);
        rd_cnt   = 0;
        saw_zero = 1'b0;
        cyc(1'b0, 16'h4014, page);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nw;
        int guard;
        bus.i_cpu_rw      = 1'b1;
        bus.i_cpu_address = 16'h0;
        bus.i_cpu_data    = 8'h0;
        rst_n = 1'b0;
        @(negedge clk);

        // Trigger on the first cycle after reset: HALT sees parity 1.
        do_reset();
        start(8'h02);
        wait_idle(600);
        check("t1_len", 32'(last_low), 32'd513);
        check("t1_first_rd", 32'(first_rd), 32'h0200);
        check("t1_last_rd", 32'(last_rd), 32'h02FF);
        check("t1_reads", 32'(rd_cnt), 32'd256);

        // One cycle later: HALT sees parity 0, adds ALIGN.
        do_reset();
        cyc(1'b1, 16'h0000, 8'h00);
        start(8'h02);
        wait_idle(600);
        check("t2_len", 32'(last_low), 32'd514);
        check("t2_first_rd", 32'(first_rd), 32'h0200);
        check("t2_reads", 32'(rd_cnt), 32'd256);

        // Page $FF stops at $FFFF without wrapping.
        do_reset();
        start(8'hFF);
        wait_idle(600);
        check("t3_last_rd", 32'(last_rd), 32'hFFFF);
        check("t3_no_zero", 32'(saw_zero), 32'h0);
        check("t3_reads", 32'(rd_cnt), 32'd256);

        // Non-trigger accesses.
        cyc(1'b1, 16'h4014, 8'h11);
        cyc(1'b0, 16'h4015, 8'h07);
        check("t4_rdy", 32'(bus.o_rdy), 32'h1);
        check("t4_active", 32'(bus.o_dma_active), 32'h0);
        check("t4_state", 32'(bus.o_debug_state), 32'(IDLE));

        // Reset during the 40th WRITE.
        start(8'h05);
        nw = 0;
        guard = 0;
        while (guard < 600) begin
            if (bus.o_debug_state == 3'(WRITE)) nw++;
            if (nw == 40) break;
            noise();
            guard++;
        end
        check("t5_found_write40", 32'(nw), 32'd40);
        rst_n = 1'b0;
        cyc(1'b1, 16'h0000, 8'h00);
        rst_n = 1'b1;
        check("t5_rdy", 32'(bus.o_rdy), 32'h1);
        check("t5_active", 32'(bus.o_dma_active), 32'h0);
        check("t5_address", 32'(bus.o_address), 32'h0);
        check("t5_rw", 32'(bus.o_rw), 32'h1);
        check("t5_data", 32'(bus.o_data), 32'h0);
        start(8'h04);
        wait_idle(600);
        check("t5_first_rd", 32'(first_rd), 32'h0400);
        check("t5_reads", 32'(rd_cnt), 32'd256);

        // Back-to-back: retrigger in the first idle cycle.
        start(8'h02);
        wait_idle(600);
        start(8'h03);
        wait_idle(600);
        check("t6_first_rd", 32'(first_rd), 32'h0300);
        check("t6_last_rd", 32'(last_rd), 32'h03FF);
        check("t6_reads", 32'(rd_cnt), 32'd256);

        // Random pages and gaps.
        repeat (4) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) noise();
            start(8'($urandom));
            wait_idle(600);
            check("rnd_reads", 32'(rd_cnt), 32'd256);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
